// File: rtl/clk_gate_ctrl.sv
// Sleep/wake controller driving the core clock-gate enable, with drain holdoff and wake settle.
// Define CLK_GATE_CTRL_SLEEP_STATS_EN to build saturating sleep statistics counters.
module clk_gate_ctrl #(
  parameter int IDLE_HOLDOFF = 8,
  parameter int WAKE_SETTLE  = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sleep_req_i,
  input  logic             bus_busy_i,
  input  logic             wake_i,
  output logic             clk_en_o,
  output logic             sleeping_o,
  output logic             wake_ack_o,
  output logic [CNT_W-1:0] sleep_cycles_o,
  output logic [CNT_W-1:0] gate_count_o
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_GATED = 2'd2;
  localparam logic [1:0] ST_WAKE  = 2'd3;

  localparam logic [7:0] HOLDOFF_LD = 8'(IDLE_HOLDOFF);
  localparam logic [7:0] SETTLE_LD  = 8'(WAKE_SETTLE);

  logic [1:0] state_q, state_d;
  logic [7:0] holdoff_q, holdoff_d;
  logic [7:0] settle_q, settle_d;
  logic       armed_q, armed_d;
  logic       wake_ack_d;
  logic       clk_en_q, sleeping_q, wake_ack_q;

  always_comb begin
    state_d    = state_q;
    holdoff_d  = holdoff_q;
    settle_d   = settle_q;
    wake_ack_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (sleep_req_i && armed_q && !wake_i) begin
          state_d   = ST_DRAIN;
          holdoff_d = HOLDOFF_LD;
        end
      end
      ST_DRAIN: begin
        if (wake_i || !sleep_req_i) begin
          state_d = ST_RUN;
        end else if (bus_busy_i) begin
          holdoff_d = HOLDOFF_LD;
        end else if (holdoff_q == 8'd1) begin
          state_d = ST_GATED;
        end else begin
          holdoff_d = holdoff_q - 8'd1;
        end
      end
      ST_GATED: begin
        if (wake_i) begin
          state_d  = ST_WAKE;
          settle_d = SETTLE_LD;
        end
      end
      ST_WAKE: begin
        if (settle_q == 8'd1) begin
          state_d    = ST_RUN;
          wake_ack_d = 1'b1;
        end else begin
          settle_d = settle_q - 8'd1;
        end
      end
      default: state_d = ST_RUN;
    endcase
    // A dropped sleep request re-arms even on the wake-completion cycle.
    armed_d = !sleep_req_i ? 1'b1 : (wake_ack_d ? 1'b0 : armed_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_RUN;
      holdoff_q  <= 8'd0;
      settle_q   <= 8'd0;
      armed_q    <= 1'b1;
      clk_en_q   <= 1'b1;
      sleeping_q <= 1'b0;
      wake_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      holdoff_q  <= holdoff_d;
      settle_q   <= settle_d;
      armed_q    <= armed_d;
      clk_en_q   <= (state_d != ST_GATED);
      sleeping_q <= (state_d == ST_GATED);
      wake_ack_q <= wake_ack_d;
    end
  end

  assign clk_en_o   = clk_en_q;
  assign sleeping_o = sleeping_q;
  assign wake_ack_o = wake_ack_q;

`ifdef CLK_GATE_CTRL_SLEEP_STATS_EN
  logic [CNT_W-1:0] sleep_cycles_q, gate_count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sleep_cycles_q <= '0;
      gate_count_q   <= '0;
    end else begin
      if (state_q == ST_GATED && sleep_cycles_q != '1)
        sleep_cycles_q <= sleep_cycles_q + CNT_W'(1);
      if (state_q == ST_DRAIN && state_d == ST_GATED && gate_count_q != '1)
        gate_count_q <= gate_count_q + CNT_W'(1);
    end
  end

  assign sleep_cycles_o = sleep_cycles_q;
  assign gate_count_o   = gate_count_q;
`else
  assign sleep_cycles_o = '0;
  assign gate_count_o   = '0;
`endif

`ifndef SYNTHESIS
  a_en_low_only_gated: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !clk_en_q |-> state_q == ST_GATED);
  a_ack_single_cycle: assert property (@(posedge clk_i) disable iff (!rst_ni)
    wake_ack_q |=> !wake_ack_q);
`endif

endmodule
